// File: rtl/mem_request_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the memory controller.
// Requester side: req/type/addr/wdata per port in, done/err per port and
// shared rdata out. Controller side: mem_request/type/address/write out,
// mem_data_in/mem_ready/mem_write_complete in. Status: grant, busy.
// slave  : arbiter view.
// master : environment view (requesters + controller).
interface mem_request_arbiter_if;
  logic        req0, req1;
  logic        type0, type1;
  logic [15:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1;
  logic        err0, err1;
  logic [15:0] rdata;
  logic        mem_request;
  logic        mem_request_type;
  logic [15:0] mem_request_address;
  logic [15:0] mem_write;
  logic [15:0] mem_data_in;
  logic        mem_ready;
  logic        mem_write_complete;
  logic        grant;
  logic        busy;

  modport slave (
    input  req0, req1, type0, type1, addr0, addr1, wdata0, wdata1,
    input  mem_data_in, mem_ready, mem_write_complete,
    output done0, done1, err0, err1, rdata,
    output mem_request, mem_request_type, mem_request_address, mem_write,
    output grant, busy
  );

  modport master (
    output req0, req1, type0, type1, addr0, addr1, wdata0, wdata1,
    output mem_data_in, mem_ready, mem_write_complete,
    input  done0, done1, err0, err1, rdata,
    input  mem_request, mem_request_type, mem_request_address, mem_write,
    input  grant, busy
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory controller.
// Port 0 is the CPU, port 1 the UART bootloader/DMA engine. One transaction
// runs at a time: the winner's type/address/data are registered, the
// controller request is held until completion (or timeout abort), then a
// one-cycle done (plus err on timeout) is returned to the winner.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_request_arbiter_if.slave (requesters, controller, status)
// All outputs are registered.
module mem_request_arbiter #(
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned TW      = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_request_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        mreq_q, mreq_d;
  logic        type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        grant_q, grant_d;
  logic        busy_q, busy_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic win;
  logic complete;

  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = '0;
    err_d    = '0;
    grant_d  = grant_q;
    cnt_d    = cnt_q;

    // On a tie the port that did not win last time goes next.
    win      = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;
    // Only the pulse matching the transaction type counts.
    complete = type_q ? bus.mem_write_complete : bus.mem_ready;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d = win;
          type_d  = win ? bus.type1  : bus.type0;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
          mreq_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Completion has priority over a timeout in the same cycle.
        if (complete) begin
          if (!type_q) rdata_d = bus.mem_data_in;
          done_d[grant_q] = 1'b1;
          mreq_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          mreq_d  = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mreq_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mreq_q  <= 1'b0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      grant_q <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_request         = mreq_q;
  assign bus.mem_request_type    = type_q;
  assign bus.mem_request_address = addr_q;
  assign bus.mem_write           = wdata_q;
  assign bus.rdata               = rdata_q;
  assign bus.done0               = done_q[0];
  assign bus.done1               = done_q[1];
  assign bus.err0                = err_q[0];
  assign bus.err1                = err_q[1];
  assign bus.grant               = grant_q;
  assign bus.busy                = busy_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
module tb_mem_request_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_request_arbiter_if bus ();

  mem_request_arbiter #(
    .TIMEOUT (8),
    .TW      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.type0 = 1'b0; bus.type1 = 1'b0;
    bus.addr0 = '0;   bus.addr1 = '0;
    bus.wdata0 = '0;  bus.wdata1 = '0;
    bus.mem_data_in = '0;
    bus.mem_ready = 1'b0;
    bus.mem_write_complete = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_mem_request", 16'(bus.mem_request), 16'h0);
    chk("rst_busy",        16'(bus.busy), 16'h0);
    chk("rst_grant",       16'(bus.grant), 16'h1);
    chk("rst_rdata",       bus.rdata, 16'h0000);
    chk("rst_addr",        bus.mem_request_address, 16'h0000);
    chk("rst_done",        16'({bus.done1, bus.done0, bus.err1, bus.err0}), 16'h0);
    rst = 1'b0;

    // Single read on port 0, ready 5 cycles after request
    bus.req0 = 1'b1; bus.type0 = 1'b0; bus.addr0 = 16'h1234;
    tick();
    chk("rd_mem_request", 16'(bus.mem_request), 16'h1);
    chk("rd_addr",        bus.mem_request_address, 16'h1234);
    chk("rd_type",        16'(bus.mem_request_type), 16'h0);
    chk("rd_grant",       16'(bus.grant), 16'h0);
    chk("rd_busy",        16'(bus.busy), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_wait_req",  16'(bus.mem_request), 16'h1);
      chk("rd_wait_done", 16'(bus.done0), 16'h0);
    end
    bus.mem_ready = 1'b1; bus.mem_data_in = 16'hBEEF;
    tick();
    chk("rd_done0",  16'(bus.done0), 16'h1);
    chk("rd_rdata",  bus.rdata, 16'hBEEF);
    chk("rd_err0",   16'(bus.err0), 16'h0);
    chk("rd_done1",  16'(bus.done1), 16'h0);
    chk("rd_req_low", 16'(bus.mem_request), 16'h0);
    bus.mem_ready = 1'b0; bus.req0 = 1'b0; bus.mem_data_in = 16'h0000;
    tick();
    chk("rd_done0_pulse", 16'(bus.done0), 16'h0);
    chk("rd_idle_busy",   16'(bus.busy), 16'h0);
    chk("rd_rdata_hold",  bus.rdata, 16'hBEEF);

    // Single write on port 1; mem_ready alone must not complete it
    bus.req1 = 1'b1; bus.type1 = 1'b1; bus.addr1 = 16'h00FF; bus.wdata1 = 16'hA5A5;
    tick();
    chk("wr_wdata", bus.mem_write, 16'hA5A5);
    chk("wr_type",  16'(bus.mem_request_type), 16'h1);
    chk("wr_addr",  bus.mem_request_address, 16'h00FF);
    chk("wr_grant", 16'(bus.grant), 16'h1);
    bus.mem_ready = 1'b1; bus.mem_data_in = 16'h1111;
    tick();
    chk("wr_ready_ignored_done", 16'(bus.done1), 16'h0);
    chk("wr_ready_ignored_req",  16'(bus.mem_request), 16'h1);
    bus.mem_ready = 1'b0; bus.mem_write_complete = 1'b1;
    tick();
    chk("wr_done1", 16'(bus.done1), 16'h1);
    chk("wr_err1",  16'(bus.err1), 16'h0);
    chk("wr_done0", 16'(bus.done0), 16'h0);
    chk("wr_rdata", bus.rdata, 16'hBEEF);
    bus.mem_write_complete = 1'b0; bus.req1 = 1'b0; bus.type1 = 1'b0;
    tick();
    chk("wr_done1_pulse", 16'(bus.done1), 16'h0);

    // Contention: both reads held, instant completion; grant was 1, so port 0 first
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 16'h0A00; bus.addr1 = 16'h0B00;
    bus.mem_ready = 1'b1; bus.mem_data_in = 16'h0C0C;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("ct_grant",    16'(bus.grant), 16'(t % 2));
      chk("ct_req_high", 16'(bus.mem_request), 16'h1);
      chk("ct_addr",     bus.mem_request_address, (t % 2 == 0) ? 16'h0A00 : 16'h0B00);
      tick();
      chk("ct_done_win",   16'({bus.done1, bus.done0}), (t % 2 == 0) ? 16'h1 : 16'h2);
      chk("ct_req_low_r",  16'(bus.mem_request), 16'h0);
      tick();
      chk("ct_done_clear", 16'({bus.done1, bus.done0}), 16'h0);
      chk("ct_req_low_i",  16'(bus.mem_request), 16'h0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0; bus.mem_data_in = 16'h0000;
    chk("ct_rdata", bus.rdata, 16'h0C0C);

    // Timeout (TIMEOUT=8): request held 9 cycles, then done0+err0
    bus.req0 = 1'b1; bus.addr0 = 16'h0042;
    tick();
    chk("to_req_1", 16'(bus.mem_request), 16'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("to_req_held", 16'(bus.mem_request), 16'h1);
      chk("to_no_done",  16'(bus.done0), 16'h0);
    end
    tick();
    chk("to_done0",   16'(bus.done0), 16'h1);
    chk("to_err0",    16'(bus.err0), 16'h1);
    chk("to_req_low", 16'(bus.mem_request), 16'h0);
    chk("to_rdata",   bus.rdata, 16'h0C0C);
    bus.req0 = 1'b0;
    tick();
    chk("to_clear", 16'({bus.done0, bus.err0}), 16'h0);

    // Completion on the timeout cycle wins
    bus.req0 = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) tick();
    chk("tc_still_req", 16'(bus.mem_request), 16'h1);
    bus.mem_ready = 1'b1; bus.mem_data_in = 16'h7777;
    tick();
    chk("tc_done0", 16'(bus.done0), 16'h1);
    chk("tc_err0",  16'(bus.err0), 16'h0);
    chk("tc_rdata", bus.rdata, 16'h7777);
    bus.mem_ready = 1'b0; bus.req0 = 1'b0;
    tick();

    // Reset mid-BUSY
    bus.req0 = 1'b1;
    tick();
    chk("rb_pre_req",   16'(bus.mem_request), 16'h1);
    chk("rb_pre_grant", 16'(bus.grant), 16'h0);
    rst = 1'b1;
    #1;
    chk("rb_async_req",  16'(bus.mem_request), 16'h0);
    chk("rb_grant",      16'(bus.grant), 16'h1);
    chk("rb_busy",       16'(bus.busy), 16'h0);
    bus.req0 = 1'b0;
    tick();
    chk("rb_no_done", 16'({bus.done1, bus.done0}), 16'h0);
    rst = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    chk("rb_tie_grant", 16'(bus.grant), 16'h0);
    bus.mem_ready = 1'b1;
    tick();
    chk("rb_tie_done0", 16'({bus.done1, bus.done0}), 16'h1);
    bus.mem_ready = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Late requester: req1 held 3 cycles after done1
    bus.req1 = 1'b1; bus.type1 = 1'b1; bus.wdata1 = 16'h5A5A;
    tick();
    chk("lr_grant", 16'(bus.grant), 16'h1);
    bus.mem_write_complete = 1'b1;
    tick();
    chk("lr_done1_a", 16'(bus.done1), 16'h1);
    bus.mem_write_complete = 1'b0;
    tick();
    chk("lr_idle_done", 16'(bus.done1), 16'h0);
    tick();
    chk("lr_second_req",  16'(bus.mem_request), 16'h1);
    chk("lr_second_done", 16'(bus.done1), 16'h0);
    tick();
    chk("lr_busy_done", 16'(bus.done1), 16'h0);
    bus.req1 = 1'b0; bus.mem_write_complete = 1'b1;
    tick();
    chk("lr_done1_b", 16'(bus.done1), 16'h1);
    bus.mem_write_complete = 1'b0;
    tick();
    chk("lr_done1_clear", 16'(bus.done1), 16'h0);
    tick();
    chk("lr_final_req",  16'(bus.mem_request), 16'h0);
    chk("lr_final_busy", 16'(bus.busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
